// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: arbitrates reply and query requests into one registered
// header slot for the ARP frame transmitter, and runs the query retransmit engine.
module arp_tx_sched #(
    parameter int RETRY_COUNT    = 4,
    parameter int RETRY_INTERVAL = 1000,
    parameter int TIMER_WIDTH    = $clog2(RETRY_INTERVAL + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        reply_valid,
    output logic        reply_ready,
    input  logic [47:0] reply_tha,
    input  logic [31:0] reply_tpa,
    input  logic        query_valid,
    output logic        query_ready,
    input  logic [31:0] query_ip,
    input  logic        query_resolved,
    output logic        query_timeout,
    output logic        m_frame_valid,
    input  logic        m_frame_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [15:0] m_arp_htype,
    output logic [15:0] m_arp_ptype,
    output logic [15:0] m_arp_oper,
    output logic [47:0] m_arp_sha,
    output logic [47:0] m_arp_tha,
    output logic [31:0] m_arp_spa,
    output logic [31:0] m_arp_tpa,
    output logic        busy,
    output logic [1:0]  dbg_query_state
);

    localparam int RETRY_WIDTH = (RETRY_COUNT > 0) ? $clog2(RETRY_COUNT + 1) : 1;

    typedef enum logic [1:0] {
        Q_IDLE = 2'd0,
        Q_SEND = 2'd1,
        Q_WAIT = 2'd2
    } q_state_e;

    q_state_e               state_q, state_d;
    logic [31:0]            query_ip_q, query_ip_d;
    logic [RETRY_WIDTH-1:0] retries_q, retries_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   timeout_q, timeout_d;
    logic                   prefer_query_q, prefer_query_d;
    logic                   frame_valid_q, frame_valid_d;
    logic [47:0]            dest_mac_q, dest_mac_d;
    logic [47:0]            src_mac_q, src_mac_d;
    logic [15:0]            eth_type_q, eth_type_d;
    logic [15:0]            htype_q, htype_d;
    logic [15:0]            ptype_q, ptype_d;
    logic [15:0]            oper_q, oper_d;
    logic [47:0]            sha_q, sha_d;
    logic [47:0]            tha_q, tha_d;
    logic [31:0]            spa_q, spa_d;
    logic [31:0]            tpa_q, tpa_d;

    logic slot_empty;
    logic query_cand;
    logic grant_reply;
    logic grant_query;

    // Arbitration: on a tie the requester not granted last time wins.
    always_comb begin
        slot_empty  = !frame_valid_q;
        query_cand  = (state_q == Q_SEND);
        grant_reply = slot_empty && reply_valid && (!query_cand || !prefer_query_q);
        grant_query = slot_empty && query_cand && (!reply_valid || prefer_query_q);
    end

    always_comb begin
        frame_valid_d  = frame_valid_q;
        prefer_query_d = prefer_query_q;
        dest_mac_d     = dest_mac_q;
        src_mac_d      = src_mac_q;
        eth_type_d     = eth_type_q;
        htype_d        = htype_q;
        ptype_d        = ptype_q;
        oper_d         = oper_q;
        sha_d          = sha_q;
        tha_d          = tha_q;
        spa_d          = spa_q;
        tpa_d          = tpa_q;

        if (frame_valid_q && m_frame_ready) begin
            frame_valid_d = 1'b0;
        end

        if (grant_reply || grant_query) begin
            frame_valid_d  = 1'b1;
            prefer_query_d = grant_reply;
            src_mac_d      = local_mac;
            eth_type_d     = 16'h0806;
            htype_d        = 16'h0001;
            ptype_d        = 16'h0800;
            sha_d          = local_mac;
            spa_d          = local_ip;
            if (grant_reply) begin
                dest_mac_d = reply_tha;
                oper_d     = 16'h0002;
                tha_d      = reply_tha;
                tpa_d      = reply_tpa;
            end else begin
                dest_mac_d = 48'hFFFF_FFFF_FFFF;
                oper_d     = 16'h0001;
                tha_d      = 48'h0;
                tpa_d      = query_ip_q;
            end
        end
    end

    // Query engine; query_resolved always beats timer expiry.
    always_comb begin
        state_d    = state_q;
        query_ip_d = query_ip_q;
        retries_d  = retries_q;
        timer_d    = timer_q;
        timeout_d  = 1'b0;

        case (state_q)
            Q_IDLE: begin
                if (query_valid) begin
                    query_ip_d = query_ip;
                    retries_d  = RETRY_WIDTH'(RETRY_COUNT);
                    state_d    = Q_SEND;
                end
            end
            Q_SEND: begin
                if (grant_query) begin
                    timer_d = TIMER_WIDTH'(RETRY_INTERVAL - 1);
                    state_d = Q_WAIT;
                end
                if (query_resolved) begin
                    state_d = Q_IDLE;
                end
            end
            Q_WAIT: begin
                if (query_resolved) begin
                    state_d = Q_IDLE;
                end else if (timer_q == '0) begin
                    if (retries_q != '0) begin
                        retries_d = retries_q - RETRY_WIDTH'(1);
                        state_d   = Q_SEND;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = Q_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end
            end
            default: begin
                state_d = Q_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= Q_IDLE;
            query_ip_q     <= '0;
            retries_q      <= '0;
            timer_q        <= '0;
            timeout_q      <= 1'b0;
            prefer_query_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            dest_mac_q     <= '0;
            src_mac_q      <= '0;
            eth_type_q     <= '0;
            htype_q        <= '0;
            ptype_q        <= '0;
            oper_q         <= '0;
            sha_q          <= '0;
            tha_q          <= '0;
            spa_q          <= '0;
            tpa_q          <= '0;
        end else begin
            state_q        <= state_d;
            query_ip_q     <= query_ip_d;
            retries_q      <= retries_d;
            timer_q        <= timer_d;
            timeout_q      <= timeout_d;
            prefer_query_q <= prefer_query_d;
            frame_valid_q  <= frame_valid_d;
            dest_mac_q     <= dest_mac_d;
            src_mac_q      <= src_mac_d;
            eth_type_q     <= eth_type_d;
            htype_q        <= htype_d;
            ptype_q        <= ptype_d;
            oper_q         <= oper_d;
            sha_q          <= sha_d;
            tha_q          <= tha_d;
            spa_q          <= spa_d;
            tpa_q          <= tpa_d;
        end
    end

    assign reply_ready     = grant_reply;
    assign query_ready     = (state_q == Q_IDLE);
    assign query_timeout   = timeout_q;
    assign m_frame_valid   = frame_valid_q;
    assign m_eth_dest_mac  = dest_mac_q;
    assign m_eth_src_mac   = src_mac_q;
    assign m_eth_type      = eth_type_q;
    assign m_arp_htype     = htype_q;
    assign m_arp_ptype     = ptype_q;
    assign m_arp_oper      = oper_q;
    assign m_arp_sha       = sha_q;
    assign m_arp_tha       = tha_q;
    assign m_arp_spa       = spa_q;
    assign m_arp_tpa       = tpa_q;
    assign busy            = frame_valid_q || (state_q != Q_IDLE);
    assign dbg_query_state = state_q;

endmodule

// File: doc/arp_tx_sched.md
Name: arp_tx_sched

Overview:
- Schedules ARP frame transmission into the ARP frame transmitter's parallel-field frame input.
- Shares that single input between two requesters:
  - the ARP reply path, fed from the ARP receiver;
  - the ARP query path, fed from an address-cache miss. This path owns the retransmit timer and retry counter.
- Builds every Ethernet/ARP header field and holds it in a one-deep output slot until the transmitter accepts it.

Parameters:
- RETRY_COUNT, 4, number of retransmissions after the first query frame (total frames = RETRY_COUNT+1).
- RETRY_INTERVAL, 1000, cycles between a query frame being loaded into the slot and its timer expiring; must be >=1.
- TIMER_WIDTH, $clog2(RETRY_INTERVAL+1), width of the interval counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- local_mac  in  48  own MAC address, sampled when a frame is loaded
- local_ip  in  32  own IPv4 address, sampled when a frame is loaded
- reply_valid  in  1  reply request pending
- reply_ready  out  1  reply request accepted when reply_valid && reply_ready
- reply_tha  in  48  requester MAC
- reply_tpa  in  32  requester IP
- query_valid  in  1  new address query
- query_ready  out  1  high when the query engine is idle
- query_ip  in  32  IP address to resolve
- query_resolved  in  1  single-cycle pulse: cache filled, stop retrying
- query_timeout  out  1  single-cycle pulse: retries exhausted
- m_frame_valid  out  1  output slot full
- m_frame_ready  in  1  transmitter accepts the slot
- m_eth_dest_mac, m_eth_src_mac  out  48  Ethernet header fields
- m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper  out  16  header fields
- m_arp_sha, m_arp_tha  out  48  ARP hardware-address fields
- m_arp_spa, m_arp_tpa  out  32  ARP protocol-address fields
- busy  out  1  m_frame_valid || query state != IDLE

Behaviour:
- Reset (async, rst=1):
  - All registers clear; m_frame_valid=0; all m_* fields=0; query_timeout=0.
  - Query state=IDLE, so query_ready=1.
  - Round-robin pointer favours reply.
- Output slot:
  - Empty when !m_frame_valid. Loading a frame sets m_frame_valid on the next edge.
  - Fields are registered and stay stable while m_frame_valid=1.
  - Slot clears on the edge where m_frame_valid && m_frame_ready.
  - The slot loads only when empty. No load in the same cycle as the ready handshake, so the maximum rate is 1 frame per 2 cycles.
- Candidates while the slot is empty: reply (reply_valid) and query (state SEND).
  - One candidate: it wins.
  - Both: round-robin; the one not granted last wins. The pointer updates on every grant.
  - reply_ready = slot empty && reply granted (combinational from state and reply_valid/query state, not from m_frame_ready).
- Reply frame fields:
  - dest=reply_tha, src=local_mac, type=0x0806, htype=0x0001, ptype=0x0800, oper=0x0002.
  - sha=local_mac, spa=local_ip, tha=reply_tha, tpa=reply_tpa.
- Query frame fields:
  - dest=48'hFFFF_FFFF_FFFF, src=local_mac, type=0x0806, htype=0x0001, ptype=0x0800, oper=0x0001.
  - sha=local_mac, spa=local_ip, tha=0, tpa=stored query_ip.
- Query FSM:
  - IDLE: on query_valid, latch query_ip, set retries_left=RETRY_COUNT, go to SEND.
  - SEND: on grant, load the frame, set timer=RETRY_INTERVAL-1, go to WAIT.
  - WAIT: timer decrements each cycle. At timer==0:
    - retries_left!=0: decrement retries_left, go to SEND.
    - retries_left==0: query_timeout=1 for the next cycle, go to IDLE.
  - The timer runs regardless of m_frame_ready (a backpressured frame still counts).
- query_resolved:
  - In SEND or WAIT: go to IDLE next cycle with no timeout pulse. A frame already in the slot is still delivered.
  - In IDLE: ignored.
  - Resolved in the same cycle as timer expiry: resolved wins, no timeout.
  - Resolved in the same cycle as a SEND grant: the frame loads and the state goes to IDLE.
- New queries: ignored unless IDLE. The query_valid/query_ready handshake completes in one cycle.
- Reset mid-operation: the slot is dropped immediately and any query is abandoned, with no timeout pulse.

Test Plan:
- Reply only: reply_valid with tha=02:00:00:00:00:01, tpa=192.168.1.10, m_frame_ready=1 → reply_ready the same cycle; next cycle m_frame_valid=1, oper=2, dest=tha, spa=local_ip; slot clears the following cycle.
- Query, no answer: RETRY_COUNT=2, RETRY_INTERVAL=10, query_ip=192.168.1.20, m_frame_ready=1 → 3 broadcast frames (oper=1, tha=0) loaded 11 cycles apart; query_timeout pulses once, 11 cycles after the 3rd load; query_ready returns to 1.
- Query resolved: assert query_resolved 5 cycles after the 1st frame → no further frames, no timeout, busy=0 once the slot drains.
- Contention: reply_valid held with query in SEND, m_frame_ready=1 → grants alternate reply, query, reply; no starvation.
- Backpressure: m_frame_ready=0 for 20 cycles with RETRY_INTERVAL=10 → frame fields stay stable; query enters SEND but is not granted until the slot drains.
- Reset mid-WAIT: pulse rst → m_frame_valid=0, query_ready=1, query_timeout never pulses.
